// File: rtl/alu_sequencer_if.sv
// Instruction-memory and ALU-side signals of alu_sequencer.
// master = sequencer side, slave = memory/ALU side.
interface alu_sequencer_if;
   logic        imem_req;
   logic [3:0]  imem_addr;
   logic        imem_valid;
   logic [11:0] imem_data;
   logic [3:0]  alu_a;
   logic [3:0]  alu_b;
   logic [3:0]  alu_opcode;
   logic [3:0]  alu_result;
   logic        alu_zero;

   modport master (
      output imem_req, imem_addr, alu_a, alu_b, alu_opcode,
      input  imem_valid, imem_data, alu_result, alu_zero
   );

   modport slave (
      input  imem_req, imem_addr, alu_a, alu_b, alu_opcode,
      output imem_valid, imem_data, alu_result, alu_zero
   );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer in front of a 4-bit ALU.
// Define ALU_SEQ_JZ_EN to build the JZ branch; otherwise op 1010 behaves as NOP.
module alu_sequencer (
   input  logic                   clk,
   input  logic                   reset,
   alu_sequencer_if.master        bus,
   input  logic [1:0]             dbg_sel,
   output logic [3:0]             dbg_data,
   output logic [3:0]             pc,
   output logic                   zflag,
   output logic                   halted,
   output logic [2:0]             dbg_state
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_WRITEBACK = 3'd3,
      S_HALTED    = 3'd4
   } state_t;

   localparam logic [3:0] OP_LDI  = 4'b1001;
   localparam logic [3:0] OP_HALT = 4'b1111;
`ifdef ALU_SEQ_JZ_EN
   localparam logic [3:0] OP_JZ   = 4'b1010;
`endif

   state_t      state;
   logic [11:0] ir;
   logic [3:0]  result;
   logic [3:0]  regs [4];

   logic [3:0]  ir_op;
   logic [1:0]  ir_rd;
   logic [1:0]  ir_rs;
   logic [3:0]  ir_imm;
   logic        ir_is_alu;
   logic        ir_writes_rd;
   logic [3:0]  pc_next;

   assign ir_op        = ir[11:8];
   assign ir_rd        = ir[7:6];
   assign ir_rs        = ir[5:4];
   assign ir_imm       = ir[3:0];
   assign ir_is_alu    = (ir_op != 4'd0) && (ir_op <= 4'd8);
   assign ir_writes_rd = ir_is_alu || (ir_op == OP_LDI);

`ifdef ALU_SEQ_JZ_EN
   assign pc_next = ((ir_op == OP_JZ) && zflag) ? ir_imm : pc + 4'd1;
`else
   assign pc_next = pc + 4'd1;
`endif

   // Instruction fetch handshake: imem_req is high for every FETCH cycle and
   // the word transfers on the rising edge where imem_req and imem_valid are
   // both high; until then imem_addr holds at pc. imem_valid is ignored
   // whenever imem_req is low.
   assign bus.imem_req  = (state == S_FETCH) && !reset;
   assign bus.imem_addr = pc;

   assign dbg_data  = regs[dbg_sel];
   assign dbg_state = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_FETCH;
         pc             <= 4'd0;
         zflag          <= 1'b0;
         ir             <= 12'd0;
         result         <= 4'd0;
         halted         <= 1'b0;
         bus.alu_a      <= 4'd0;
         bus.alu_b      <= 4'd0;
         bus.alu_opcode <= 4'd0;
         for (int i = 0; i < 4; i++) begin
            regs[i] <= 4'd0;
         end
      end else begin
         case (state)
            S_FETCH: begin
               if (bus.imem_valid) begin
                  ir    <= bus.imem_data;
                  state <= S_DECODE;
               end
            end

            S_DECODE: begin
               // Operands stay parked here so the ALU settles through EXECUTE.
               if (ir_is_alu) begin
                  bus.alu_a      <= regs[ir_rd];
                  bus.alu_b      <= regs[ir_rs];
                  bus.alu_opcode <= ir_op;
               end else begin
                  bus.alu_opcode <= 4'd0;
               end
               state <= S_EXECUTE;
            end

            S_EXECUTE: begin
               if (ir_is_alu) begin
                  result <= bus.alu_result;
                  zflag  <= bus.alu_zero;
               end else if (ir_op == OP_LDI) begin
                  result <= ir_imm;
               end
               if (ir_op == OP_HALT) begin
                  halted <= 1'b1;
                  state  <= S_HALTED;
               end else begin
                  state  <= S_WRITEBACK;
               end
            end

            S_WRITEBACK: begin
               if (ir_writes_rd) begin
                  regs[ir_rd] <= result;
               end
               pc    <= pc_next;
               state <= S_FETCH;
            end

            S_HALTED: begin
               state <= S_HALTED;
            end

            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer with a behavioural ALU and
// an instruction-level reference model of the architectural state.
module tb_alu_sequencer;

   localparam int W = 33;
`ifdef ALU_SEQ_JZ_EN
   localparam bit JZ_EN = 1'b1;
`else
   localparam bit JZ_EN = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic [1:0] dbg_sel;
   logic [3:0] dbg_data;
   logic [3:0] pc;
   logic       zflag;
   logic       halted;
   logic [2:0] dbg_state;

   alu_sequencer_if ifc ();

   alu_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (ifc.master),
      .dbg_sel   (dbg_sel),
      .dbg_data  (dbg_data),
      .pc        (pc),
      .zflag     (zflag),
      .halted    (halted),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural ALU ----------------
   function automatic logic [3:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      int r;
      case (op)
         4'd1:    r = int'(a) + int'(b);
         4'd2:    r = int'(a) - int'(b) + 16;
         4'd3:    r = int'(a & b);
         4'd4:    r = int'(a | b);
         4'd5:    r = int'(a ^ b);
         4'd6:    r = 15 - int'(a);
         4'd7:    r = int'(a) * 2;
         4'd8:    r = int'(a) / 2;
         default: r = 0;
      endcase
      return 4'(r % 16);
   endfunction

   always_comb begin
      ifc.alu_result = alu_fn(ifc.alu_opcode, ifc.alu_a, ifc.alu_b);
      ifc.alu_zero   = (ifc.alu_result == 4'd0);
   end

   // ---------------- reference model ----------------
   logic [3:0] m_regs [4];
   logic [3:0] m_pc, m_a, m_b, m_op;
   logic       m_z;
   logic [W-1:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
      m_pc = 4'd0; m_a = 4'd0; m_b = 4'd0; m_op = 4'd0; m_z = 1'b0;
   endtask

   // Applies one instruction to the architectural state.
   task automatic model_exec(input logic [11:0] instr);
      logic [3:0] op, imm, r;
      logic [1:0] rd, rs;
      op = instr[11:8]; rd = instr[7:6]; rs = instr[5:4]; imm = instr[3:0];
      if (op >= 4'd1 && op <= 4'd8) begin
         m_a = m_regs[rd];
         m_b = m_regs[rs];
         m_op = op;
         r = alu_fn(op, m_a, m_b);
         m_z = (r == 4'd0);
         m_regs[rd] = r;
         m_pc = m_pc + 4'd1;
      end else if (op == 4'd15) begin
         m_op = 4'd0;
      end else begin
         m_op = 4'd0;
         if (op == 4'd9) m_regs[rd] = imm;
         if (op == 4'd10 && JZ_EN && m_z) m_pc = imm;
         else m_pc = m_pc + 4'd1;
      end
   endtask

   function automatic logic [W-1:0] model_pack();
      return {m_pc, m_z, m_op, m_a, m_b, m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
   endfunction

   function automatic logic [11:0] mk(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [3:0] imm);
      return {op, rd, rs, imm};
   endfunction

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      reset = 1'b1;
      ifc.imem_valid = 1'b0;
      #2;
      check("rst_imem_req", {3'd0, ifc.imem_req}, 4'd0);
      check("rst_pc", pc, 4'd0);
      check("rst_zflag", {3'd0, zflag}, 4'd0);
      check("rst_halted", {3'd0, halted}, 4'd0);
      check("rst_alu_a", ifc.alu_a, 4'd0);
      check("rst_alu_b", ifc.alu_b, 4'd0);
      check("rst_alu_opcode", ifc.alu_opcode, 4'd0);
      check("rst_state", {1'b0, dbg_state}, 4'd0);
      for (int i = 0; i < 4; i++) begin
         dbg_sel = 2'(i);
         #1;
         check("rst_reg", dbg_data, 4'd0);
      end
      model_reset();
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("post_rst_req", {3'd0, ifc.imem_req}, 4'd1);
      check("post_rst_addr", ifc.imem_addr, 4'd0);
      @(negedge clk); #1;
   endtask

   task automatic wait_fetch();
      int cyc = 0;
      while (!ifc.imem_req && cyc < 50) begin
         @(posedge clk); #1; cyc++;
      end
      check("fetch_wait", {3'd0, ifc.imem_req}, 4'd1);
   endtask

   task automatic issue(input logic [11:0] instr, input int stalls);
      int cyc;
      logic [3:0] pre_pc;
      wait_fetch();
      pre_pc = m_pc;
      check("fetch_addr", ifc.imem_addr, pre_pc);
      cyc = 0;
      for (int s = 0; s < stalls; s++) begin
         ifc.imem_valid = 1'b0;
         ifc.imem_data = 12'($urandom);
         @(posedge clk); #1; cyc++;
         check("stall_req", {3'd0, ifc.imem_req}, 4'd1);
         check("stall_addr", ifc.imem_addr, pre_pc);
      end
      ifc.imem_data = instr;
      ifc.imem_valid = 1'b1;
      dbg_sel = 2'($urandom_range(0, 3));
      model_exec(instr);
      if (instr[11:8] != 4'd15) exp_q.push_back(model_pack());
      @(posedge clk); #1; cyc++;
      ifc.imem_valid = 1'b0;
      if (instr[11:8] == 4'd15) begin
         while (!halted && cyc < stalls + 20) begin
            @(posedge clk); #1; cyc++;
         end
         check("halt_latency", 4'(cyc - stalls), 4'd3);
         check("halt_req", {3'd0, ifc.imem_req}, 4'd0);
      end else begin
         while (!ifc.imem_req && cyc < stalls + 20) begin
            // imem_valid toggles with junk data while the DUT is not fetching
            ifc.imem_valid = 1'($urandom_range(0, 1));
            ifc.imem_data = 12'($urandom);
            @(posedge clk); #1; cyc++;
         end
         ifc.imem_valid = 1'b0;
         check("instr_latency", 4'(cyc - stalls), 4'd4);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic prev_req;
      logic [W-1:0] e;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (ifc.imem_req && !prev_req && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ret_pc", pc, e[32:29]);
            check("ret_zflag", {3'd0, zflag}, {3'd0, e[28]});
            check("ret_alu_opcode", ifc.alu_opcode, e[27:24]);
            check("ret_alu_a", ifc.alu_a, e[23:20]);
            check("ret_alu_b", ifc.alu_b, e[19:16]);
            check("ret_dbg_data", dbg_data, e[4*dbg_sel +: 4]);
         end
         prev_req = ifc.imem_req;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      logic [3:0] op;
      reset = 1'b1;
      ifc.imem_valid = 1'b0;
      ifc.imem_data = 12'd0;
      dbg_sel = 2'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // arithmetic chain: r0 = 3 + 5
      issue(mk(4'd9, 2'd0, 2'd0, 4'd3), 0);
      issue(mk(4'd9, 2'd1, 2'd0, 4'd5), 0);
      issue(mk(4'd1, 2'd0, 2'd1, 4'd0), 0);

      // overflow to zero, then JZ 0
      issue(mk(4'd9, 2'd0, 2'd0, 4'hF), 0);
      issue(mk(4'd9, 2'd1, 2'd0, 4'd1), 0);
      issue(mk(4'd1, 2'd0, 2'd1, 4'd0), 0);
      issue(mk(4'd10, 2'd0, 2'd0, 4'd0), 0);

      // three-cycle fetch stall
      issue(mk(4'd9, 2'd3, 2'd0, 4'd6), 3);

      // flag hold across LDI, then NOT clears it; JZ not taken
      issue(mk(4'd2, 2'd2, 2'd2, 4'd0), 0);
      issue(mk(4'd9, 2'd2, 2'd0, 4'd7), 1);
      issue(mk(4'd6, 2'd2, 2'd0, 4'd0), 0);
      issue(mk(4'd10, 2'd0, 2'd0, 4'd5), 2);

      // randomized instruction stream (HALT excluded)
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 14));
         issue(mk(op, 2'($urandom), 2'($urandom), 4'($urandom)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      // PC wrap: 16 NOP-class instructions from PC=0, then HALT
      do_reset();
      for (int i = 0; i < 16; i++) begin
         op = (i % 2 == 0) ? 4'd0 : 4'($urandom_range(11, 14));
         issue(mk(op, 2'($urandom), 2'($urandom), 4'($urandom)), 0);
      end
      issue(mk(4'd15, 2'd0, 2'd0, 4'd0), 0);
      for (int i = 0; i < 22; i++) begin
         ifc.imem_valid = 1'($urandom_range(0, 1));
         ifc.imem_data = 12'($urandom);
         @(posedge clk); #1;
         if (i % 4 == 0) begin
            check("halt_hold", {3'd0, halted}, 4'd1);
            check("halt_no_req", {3'd0, ifc.imem_req}, 4'd0);
            check("halt_pc", pc, m_pc);
         end
      end

      // reset during EXECUTE of ADD r0,r1 discards it
      do_reset();
      issue(mk(4'd9, 2'd0, 2'd0, 4'd3), 0);
      issue(mk(4'd9, 2'd1, 2'd0, 4'd5), 0);
      wait_fetch();
      ifc.imem_data = mk(4'd1, 2'd0, 2'd1, 4'd0);
      ifc.imem_valid = 1'b1;
      @(posedge clk); #1;
      ifc.imem_valid = 1'b0;
      @(posedge clk); #1;
      check("exec_alu_a", ifc.alu_a, 4'd3);
      check("exec_alu_b", ifc.alu_b, 4'd5);
      check("exec_alu_opcode", ifc.alu_opcode, 4'd1);
      do_reset();
      issue(mk(4'd9, 2'd2, 2'd0, 4'd9), 0);

      cyc = 0;
      while (exp_q.size() > 0 && cyc < 20) begin
         @(posedge clk); #1; cyc++;
      end
      check("scoreboard_drain", 4'(exp_q.size()), 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
